// File: rtl/regfile_preloader_pkg.sv
// rtl/regfile_preloader_pkg.sv - shared widths, defaults and state encoding for the regfile preloader
package preload_pkg;
   localparam int REG_ADDR_W        = 5;
   localparam int REG_DATA_W        = 32;
   localparam int DEFAULT_FIRST_REG = 1;
   localparam int DEFAULT_LAST_REG  = 31;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_e;
endpackage

// File: rtl/regfile_preloader_if.sv
// rtl/regfile_preloader_if.sv - processor-side and regfile-side write ports around the preloader
interface regfile_preloader_if;
   import preload_pkg::*;

   logic                  proc_writeEnable;
   logic [REG_ADDR_W-1:0] proc_writeReg;
   logic [REG_DATA_W-1:0] proc_writeData;
   logic                  ctrl_writeEnable;
   logic [REG_ADDR_W-1:0] ctrl_writeReg;
   logic [REG_DATA_W-1:0] data_writeReg;

   // master is the surrounding skeleton (processor + regfile), slave is the preloader
   modport master (
      output proc_writeEnable, proc_writeReg, proc_writeData,
      input  ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );
   modport slave (
      input  proc_writeEnable, proc_writeReg, proc_writeData,
      output ctrl_writeEnable, ctrl_writeReg, data_writeReg
   );
endinterface

// File: rtl/regfile_preloader.sv
// rtl/regfile_preloader.sv - streams preload ROM contents into the regfile, then passes the processor's write port through
module regfile_preloader
   import preload_pkg::*;
#(
   parameter int FIRST_REG = DEFAULT_FIRST_REG,
   parameter int LAST_REG  = DEFAULT_LAST_REG
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   output logic [REG_ADDR_W-1:0] rom_address,
   input  logic [REG_DATA_W-1:0] rom_q,
   regfile_preloader_if.slave    wr,
   output logic                  proc_hold,
   output logic                  busy,
   output logic                  done
);
   localparam logic [REG_ADDR_W-1:0] FIRST = FIRST_REG[REG_ADDR_W-1:0];
   localparam logic [REG_ADDR_W-1:0] LAST  = LAST_REG[REG_ADDR_W-1:0];
   // With a one-register range the read pointer must already sit at LAST after PRIME
   localparam int                    PRIME_RD_I = (FIRST_REG < LAST_REG) ? FIRST_REG + 1 : LAST_REG;
   localparam logic [REG_ADDR_W-1:0] PRIME_RD   = PRIME_RD_I[REG_ADDR_W-1:0];

   state_e                state_q, state_d;
   logic [REG_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [REG_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic                  hold_q, busy_q, done_q;

   always_comb begin
      state_d  = state_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               rd_ptr_d = FIRST;
               state_d  = ST_PRIME;
            end
         end
         ST_PRIME: begin
            wr_ptr_d = FIRST;
            rd_ptr_d = PRIME_RD;
            state_d  = ST_STREAM;
         end
         ST_STREAM: begin
            wr_ptr_d = wr_ptr_q + 5'd1;
            rd_ptr_d = (rd_ptr_q == LAST) ? LAST : rd_ptr_q + 5'd1;
            if (wr_ptr_q == LAST) begin
               state_d = ST_DONE;
            end
         end
      endcase
   end

   // Flags are registered from the next state so they change only on a clock edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         hold_q   <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         hold_q   <= (state_d != ST_DONE);
         busy_q   <= (state_d == ST_PRIME) || (state_d == ST_STREAM);
         done_q   <= (state_d == ST_DONE);
      end
   end

   // DONE is a pure wire path so the processor sees no extra write latency
   always_comb begin
      wr.ctrl_writeEnable = 1'b0;
      wr.ctrl_writeReg    = '0;
      wr.data_writeReg    = '0;
      unique case (state_q)
         ST_STREAM: begin
            wr.ctrl_writeEnable = 1'b1;
            wr.ctrl_writeReg    = wr_ptr_q;
            wr.data_writeReg    = rom_q;
         end
         ST_DONE: begin
            wr.ctrl_writeEnable = wr.proc_writeEnable;
            wr.ctrl_writeReg    = wr.proc_writeReg;
            wr.data_writeReg    = wr.proc_writeData;
         end
         ST_IDLE, ST_PRIME: begin
            wr.ctrl_writeEnable = 1'b0;
         end
      endcase
   end

   assign rom_address = rd_ptr_q;
   assign proc_hold   = hold_q;
   assign busy        = busy_q;
   assign done        = done_q;
endmodule

// File: tb/tb_regfile_preloader.sv
// tb/tb_regfile_preloader.sv - directed self-checking bench for regfile_preloader
module tb_regfile_preloader;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start1 = 1'b0;
   logic        start2 = 1'b0;
   logic [4:0]  rom_address1, rom_address2;
   logic [31:0] rom_q1, rom_q2;
   logic        proc_hold1, busy1, done1;
   logic        proc_hold2, busy2, done2;

   logic [31:0] rom1 [32];
   logic [31:0] rom2 [32];
   logic [31:0] rf1 [32] = '{default: 32'd0};
   logic [31:0] rf2 [32] = '{default: 32'd0};
   int          load_writes1 = 0;
   int          load_writes2 = 0;
   int          r0_hits = 0;
   int          order_err = 0;
   logic [4:0]  prev_reg = 5'd0;

   int checks = 0;
   int errors = 0;
   int edges;
   int base_writes;
   int base_order;

   regfile_preloader_if if1 ();
   regfile_preloader_if if2 ();

   regfile_preloader dut1 (
      .clock(clock), .reset(reset), .start(start1),
      .rom_address(rom_address1), .rom_q(rom_q1), .wr(if1),
      .proc_hold(proc_hold1), .busy(busy1), .done(done1)
   );

   regfile_preloader #(.FIRST_REG(7), .LAST_REG(7)) dut2 (
      .clock(clock), .reset(reset), .start(start2),
      .rom_address(rom_address2), .rom_q(rom_q2), .wr(if2),
      .proc_hold(proc_hold2), .busy(busy2), .done(done2)
   );

   always #5 clock = ~clock;

   // Synchronous ROMs and regfile models living in the skeleton
   always @(posedge clock) begin
      rom_q1 <= rom1[rom_address1];
      rom_q2 <= rom2[rom_address2];
      if (if1.ctrl_writeEnable) begin
         rf1[if1.ctrl_writeReg] <= if1.data_writeReg;
         if (busy1) begin
            load_writes1 <= load_writes1 + 1;
            if (if1.ctrl_writeReg == 5'd0) r0_hits <= r0_hits + 1;
            if (if1.ctrl_writeReg != 5'd1 && if1.ctrl_writeReg != prev_reg + 5'd1)
               order_err <= order_err + 1;
            prev_reg <= if1.ctrl_writeReg;
         end
      end
      if (if2.ctrl_writeEnable) begin
         rf2[if2.ctrl_writeReg] <= if2.data_writeReg;
         load_writes2 <= load_writes2 + 1;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulses start on dut1 and counts edges (including the start edge) until done
   task automatic run_load(input bit repulse, output int n);
      start1 = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         start1 = repulse && (n == 11);
         if (n == 1) begin
            check("busy_after_e0", {31'd0, busy1}, 32'd1);
            check("hold_after_e0", {31'd0, proc_hold1}, 32'd1);
            check("rom_addr_after_e0", {27'd0, rom_address1}, 32'd1);
         end
      end while (!done1 && n < 100);
      start1 = 1'b0;
   endtask

   initial begin
      if1.proc_writeEnable = 1'b0;
      if1.proc_writeReg    = 5'd0;
      if1.proc_writeData   = 32'd0;
      if2.proc_writeEnable = 1'b0;
      if2.proc_writeReg    = 5'd0;
      if2.proc_writeData   = 32'd0;
      for (int i = 0; i < 32; i++) begin
         rom1[i] = (i == 1) ? 32'd65535 : 32'(3 * i);
         rom2[i] = 32'd0;
      end
      rom2[7] = 32'd42;

      tick();
      tick();
      check("rst_hold", {31'd0, proc_hold1}, 32'd1);
      check("rst_busy", {31'd0, busy1}, 32'd0);
      check("rst_done", {31'd0, done1}, 32'd0);
      check("rst_rom_addr", {27'd0, rom_address1}, 32'd0);
      check("rst_we", {31'd0, if1.ctrl_writeEnable}, 32'd0);
      reset = 1'b0;
      tick();

      // Processor write before any load must be dropped
      if1.proc_writeEnable = 1'b1;
      if1.proc_writeReg    = 5'd5;
      if1.proc_writeData   = 32'hDEAD;
      #1;
      check("idle_we_blocked", {31'd0, if1.ctrl_writeEnable}, 32'd0);
      tick();
      check("idle_r5_untouched", rf1[5], 32'd0);
      check("idle_hold", {31'd0, proc_hold1}, 32'd1);
      if1.proc_writeEnable = 1'b0;

      // Full default load with an ignored start pulse in the 10th STREAM cycle
      base_writes = load_writes1;
      base_order  = order_err;
      run_load(1'b1, edges);
      check("full_edges", 32'(edges), 32'd33);
      check("full_writes", 32'(load_writes1 - base_writes), 32'd31);
      check("full_order", 32'(order_err - base_order), 32'd0);
      check("full_r1", rf1[1], 32'd65535);
      check("full_r31", rf1[31], 32'd93);
      check("full_r0_hits", 32'(r0_hits), 32'd0);
      check("full_r0", rf1[0], 32'd0);
      check("done_hold", {31'd0, proc_hold1}, 32'd0);
      check("done_busy", {31'd0, busy1}, 32'd0);

      // Pass-through is combinational in DONE
      if1.proc_writeEnable = 1'b1;
      if1.proc_writeReg    = 5'd5;
      if1.proc_writeData   = 32'hDEAD;
      #1;
      check("pt_we", {31'd0, if1.ctrl_writeEnable}, 32'd1);
      check("pt_reg", {27'd0, if1.ctrl_writeReg}, 32'd5);
      check("pt_data", if1.data_writeReg, 32'hDEAD);
      tick();
      if1.proc_writeEnable = 1'b0;
      check("pt_r5", rf1[5], 32'hDEAD);

      // Reload from DONE with new ROM contents
      for (int i = 0; i < 32; i++) rom1[i] = 32'(i + 100);
      base_writes = load_writes1;
      run_load(1'b0, edges);
      check("reload_edges", 32'(edges), 32'd33);
      check("reload_writes", 32'(load_writes1 - base_writes), 32'd31);
      check("reload_r1", rf1[1], 32'd101);
      check("reload_r5", rf1[5], 32'd105);
      check("reload_r31", rf1[31], 32'd131);

      // Reset while r12 is on the write port
      for (int i = 0; i < 32; i++) rom1[i] = 32'(7 * i);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      edges = 0;
      while (!(if1.ctrl_writeEnable && if1.ctrl_writeReg == 5'd12) && edges < 100) begin
         tick();
         edges++;
      end
      check("midrst_reached_r12", {27'd0, if1.ctrl_writeReg}, 32'd12);
      reset = 1'b1;
      #1;
      check("midrst_we", {31'd0, if1.ctrl_writeEnable}, 32'd0);
      check("midrst_busy", {31'd0, busy1}, 32'd0);
      check("midrst_hold", {31'd0, proc_hold1}, 32'd1);
      check("midrst_rom_addr", {27'd0, rom_address1}, 32'd0);
      for (int i = 1; i <= 11; i++) check($sformatf("midrst_r%0d", i), rf1[i], 32'(7 * i));
      check("midrst_r12_old", rf1[12], 32'd112);
      tick();
      reset = 1'b0;
      tick();
      base_writes = load_writes1;
      run_load(1'b0, edges);
      check("after_rst_edges", 32'(edges), 32'd33);
      check("after_rst_writes", 32'(load_writes1 - base_writes), 32'd31);
      check("after_rst_r12", rf1[12], 32'd84);
      check("after_rst_r31", rf1[31], 32'd217);

      // Single-register range on the second instance
      start2 = 1'b1;
      edges = 0;
      do begin
         tick();
         edges++;
         start2 = 1'b0;
         if (busy2) check($sformatf("narrow_rd_ptr_e%0d", edges), {27'd0, rom_address2}, 32'd7);
      end while (!done2 && edges < 100);
      check("narrow_edges", 32'(edges), 32'd3);
      check("narrow_writes", 32'(load_writes2), 32'd1);
      check("narrow_r7", rf2[7], 32'd42);
      check("narrow_rd_ptr_done", {27'd0, rom_address2}, 32'd7);
      check("narrow_r6", rf2[6], 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/regfile_preloader.md
# regfile_preloader

Sequential initializer for the processor's register file. After reset it holds the processor in reset. On a `start` pulse it streams initial register values from a small synchronous ROM into the regfile write port, one register per cycle. It then releases the processor and becomes a transparent pass-through for the processor's own write port. It sits between the processor's regfile write outputs and the regfile inside `skeleton`, and writes registers in the same way the processor writes them.

## Interface
- `FIRST_REG`, default 1: first register loaded; must be ≥1, so r0 is never written.
- `LAST_REG`, default 31: last register loaded; FIRST_REG ≤ LAST_REG ≤ 31.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: a one-cycle pulse that starts a load; sampled only in IDLE or DONE.
- `rom_address` out 5: register index presented to the preload ROM.
- `rom_q` in 32: ROM data; registered read, valid one cycle after the address is captured.
- `proc_writeEnable` in 1, `proc_writeReg` in 5, `proc_writeData` in 32: the processor's regfile write port.
- `ctrl_writeEnable` out 1, `ctrl_writeReg` out 5, `data_writeReg` out 32: the write port to the regfile.
- `proc_hold` out 1: high keeps the processor in reset; it is ORed into the processor's reset by the top level.
- `busy` out 1: high while a load is in progress.
- `done` out 1: high once a load has completed, until reset or the next start.

## Operation
- The block has four states: IDLE, PRIME, STREAM and DONE.
- There are two 5-bit pointers:
  - `rd_ptr` drives `rom_address` directly.
  - `wr_ptr` is the register being written.
- Reset values:
  - state = IDLE, `rd_ptr` = `wr_ptr` = 0.
  - `rom_address` = 0, `ctrl_writeEnable` = 0, `ctrl_writeReg` = 0, `data_writeReg` = 0.
  - `proc_hold` = 1, `busy` = 0, `done` = 0.
- IDLE:
  - Write-port outputs are all 0 and the processor's write port is ignored.
  - When `start` is high: `rd_ptr` ← FIRST_REG, then go to PRIME.
- PRIME:
  - Write-port outputs are 0; this state only absorbs the ROM latency.
  - Unconditionally: `wr_ptr` ← FIRST_REG, `rd_ptr` ← FIRST_REG+1, then go to STREAM.
- STREAM:
  - `ctrl_writeEnable` = 1, `ctrl_writeReg` = `wr_ptr`, `data_writeReg` = `rom_q`.
  - Every edge: `wr_ptr`++ and `rd_ptr`++.
  - `rd_ptr` saturates at LAST_REG and never wraps to 0.
  - On the edge where `wr_ptr` == LAST_REG, go to DONE.
- DONE:
  - The write outputs equal the processor inputs combinationally (`proc_writeEnable`, `proc_writeReg`, `proc_writeData`).
  - When `start` is high: begin a new load exactly as from IDLE. The pass-through is dropped on that same edge.
- Flags:
  - `proc_hold` = (state ≠ DONE).
  - `busy` = (state ∈ {PRIME, STREAM}).
  - `done` = (state == DONE).
  - All three are decoded from registered state, so none of them glitches.
- `start` during PRIME or STREAM is ignored; it neither restarts nor extends the load.
- Processor write attempts in any state other than DONE are dropped. No write from the processor can collide with a preload write.
- Reset asserted mid-load:
  - The block returns to IDLE immediately and asynchronously.
  - Registers already written keep their values.
  - A new `start` reloads the whole range.

## Timing
- Let E0 be the edge at which `start` is sampled, and N = LAST_REG − FIRST_REG + 1.
- After E0: PRIME, `busy` = 1, `rom_address` = FIRST_REG.
- At E1: the ROM captures FIRST_REG. After E1, `rom_q` = mem[FIRST_REG] and the state is STREAM.
- Edges E2 … E(N+1) each commit one register: register FIRST_REG+k is written at E(k+2).
- After E(N+1): DONE, `busy` = 0, `done` = 1, `proc_hold` = 0.
- Total: N+2 edges from start to release; 33 cycles with the defaults.
- The pass-through in DONE has zero latency. The block adds no register stage to the processor's write path.
- With FIRST_REG == LAST_REG, STREAM lasts exactly one cycle.

## Structure
- A shared package `preload_pkg` holds:
  - the state encoding localparams (2 bits);
  - `REG_ADDR_W` = 5 and `REG_DATA_W` = 32;
  - the default FIRST_REG and LAST_REG.
- No sub-module is needed.
- The pointer and state logic form a single always block.
- The output mux is a separate combinational block selected by state.
- The ROM lives outside the block, in `skeleton`, alongside imem and dmem.

## Test plan
- **Full default load.** ROM mem[1] = 65535 and mem[i] = 3·i for i ≥ 2; pulse `start`. Required:
  - exactly 31 writes, r1…r31, one per cycle;
  - `done` rises 33 edges after start;
  - r1 reads 65535 and r31 reads 93;
  - r0 is never written.
- **Hold and pass-through.**
  - Before `start`: `proc_hold` = 1, and a processor write of 0xDEAD to r5 is dropped.
  - After `done`: the same write appears on `ctrl_*` in the same cycle and r5 reads 0xDEAD.
- **Start while busy.** Pulse `start` again at the 10th STREAM cycle. Required: no restart, `done` still at edge 33, 31 writes in total.
- **Reset mid-load.** Assert `reset` during the write to r12. Required:
  - outputs return to reset values immediately;
  - r1–r11 hold the ROM values;
  - a new `start` completes a full load.
- **Narrow range.** FIRST_REG = LAST_REG = 7, mem[7] = 42. Required:
  - one write to r7 = 42;
  - `done` after 3 edges;
  - `rd_ptr` holds at 7.
- **Reload from DONE.**
  - Change the ROM contents, then pulse `start` in DONE.
  - Required: `proc_hold` reasserts on the next cycle and all registers take the new values.
